// File: rtl/load_store_unit.sv
// Load/store unit: executes one RV32I load or store per request against a
// single-port synchronous RAM; byte/half stores are done as read-modify-write.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [29:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LOAD, S_WRITE, S_DONE} state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_mem_re;
  logic        r_mem_we;
  logic [31:0] r_rdata;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_accept;
  logic        w_req_err;
  logic [31:0] w_load_val;
  logic [31:0] w_store_val;

  function automatic logic access_error(input logic st, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic bad_code;
    if (st) bad_code = (f3 >= 3'd3);
    else    bad_code = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    return bad_code || ((f3[1:0] == 2'd1) && a[0]) ||
           ((f3[1:0] == 2'd2) && (a != 2'd0));
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0] f3,
                                              input logic [1:0] a);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    return 32'(b);
      3'd1:    return 32'(h);
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [2:0] f3,
                                              input logic [1:0] a);
    logic [31:0] res;
    res = word;
    if (f3[1:0] == 2'd0)      res[{a, 3'b000} +: 8]     = wd[7:0];
    else if (f3[1:0] == 2'd1) res[{a[1], 4'b0000} +: 16] = wd[15:0];
    else                      res = wd;
    return res;
  endfunction

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_req_err   = access_error(store, funct3, addr[1:0]);
  assign w_load_val  = load_extend(mem_dout, r_funct3, r_addr[1:0]);
  // RAM data for the merge arrives during WRITE, so the lane splice stays combinational
  assign w_store_val = store_merge(mem_dout, r_wdata, r_funct3, r_addr[1:0]);

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign rdata    = r_rdata;
  assign mem_addr = r_addr[31:2];
  assign mem_re   = r_mem_re;
  assign mem_we   = r_mem_we;
  assign mem_din  = w_store_val;

  // request capture: data only, no reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_store  <= store;
      r_funct3 <= funct3;
      r_addr   <= addr;
      r_wdata  <= wdata;
    end
  end

  // control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (w_req_err) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (store && (funct3 == 3'd2)) begin
              r_state  <= S_WRITE;
              r_mem_we <= 1'b1;
            end else begin
              r_state  <= S_READ;
              r_mem_re <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (r_store) begin
            r_state  <= S_WRITE;
            r_mem_we <= 1'b1;
          end else begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_rdata <= w_load_val;
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_WRITE: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 Port rst, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-003 Port start, input, 1 bit: request strobe, sampled only in IDLE.
REQ-004 Port store, input, 1 bit: 1 = store, 0 = load; captured with start.
REQ-005 Port funct3, input, 3 bits: RV32I width/sign code (0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU); captured with start.
REQ-006 Port addr, input, 32 bits: byte address (ALU result); captured with start.
REQ-007 Port wdata, input, 32 bits: store data (rs2 value); captured with start.
REQ-008 Port busy, output, 1 bit: high in every state except IDLE.
REQ-009 Port done, output, 1 bit: one-cycle completion pulse.
REQ-010 Port err, output, 1 bit: valid with done; misaligned or illegal funct3.
REQ-011 Port rdata, output, 32 bits: registered, extended load result; holds until the next load completes.
REQ-012 Port mem_addr, output, 30 bits: word address to synchronous RAM, equal to captured addr[31:2].
REQ-013 Ports mem_re and mem_we, outputs, 1 bit each: RAM read and write enables.
REQ-014 Port mem_din, output, 32 bits: RAM write data.
REQ-015 Port mem_dout, input, 32 bits: RAM read data, valid the cycle after mem_re was high at a clock edge.

Function
REQ-016 The FSM SHALL have states IDLE, READ, LOAD, WRITE, DONE.
REQ-017 IDLE with start=1 SHALL capture store, funct3, addr and wdata, then select the next state.
  - error -> DONE
  - load -> READ
  - SW -> WRITE
  - SB/SH -> READ
REQ-018 Error conditions SHALL be as follows; no RAM access occurs on error.
  - halfword access with addr[0]=1
  - word access with addr[1:0]!=0
  - load funct3 in {3,6,7}
  - store funct3 >= 3
REQ-019 READ SHALL drive mem_re=1 for exactly one cycle.
  - next state LOAD for loads
  - next state WRITE for SB/SH
REQ-020 LOAD SHALL register rdata from mem_dout and go to DONE.
  - select byte lane addr[1:0] or half lane addr[1]
  - sign-extend for funct3 0/1; zero-extend for 4/5
  - LW passes the word unchanged
REQ-021 WRITE SHALL drive mem_we=1 for exactly one cycle, then go to DONE.
  - SW: mem_din = wdata
  - SB/SH: mem_din = mem_dout with only the addressed lane replaced by wdata[7:0] or wdata[15:0]
REQ-022 DONE SHALL assert done=1 for one cycle, drive err per REQ-018, then go to IDLE.
REQ-023 Latency from the start-accepting edge to done high SHALL be fixed.
  - error: 1 cycle
  - SW: 2 cycles
  - SB/SH/loads: 3 cycles
REQ-024 mem_re and mem_we SHALL never be high in the same cycle, and both SHALL be 0 in IDLE and DONE.
REQ-025 start outside IDLE SHALL be ignored; a start in the same cycle as done SHALL be ignored.
REQ-026 err SHALL be 0 whenever done=0; rdata SHALL be unchanged by stores and errored loads.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE and clear the following outputs, overriding start in that cycle.
  - busy, done, err, mem_re, mem_we = 0
  - rdata = 0
REQ-028 Reset mid-operation SHALL abort with no done pulse; a pending WRITE-state write SHALL NOT occur after the reset edge.

Verification
REQ-029 RAM word 0x10 = 0x8899AABB; LB addr 0x41 -> one mem_re at mem_addr 0x10; done 3 cycles after start, rdata = 0xFFFFFFAA, err=0.
REQ-030 Same word; LHU addr 0x42 -> rdata = 0x00008899; LH addr 0x42 -> rdata = 0xFFFF8899.
REQ-031 Same word; SB addr 0x43, wdata 0x12345677 -> one read, then one write with mem_din = 0x7799AABB; done at cycle 3.
REQ-032 SW addr 0x44, wdata 0xDEADBEEF -> no mem_re, one mem_we with mem_din = 0xDEADBEEF; done at cycle 2.
REQ-033 LW addr 0x46 -> no mem_re/mem_we, done at cycle 1 with err=1, rdata unchanged; same for load funct3=3.
REQ-034 SH addr 0x40 with rst=1 during WRITE -> no mem_we after the reset edge, no done; start held high during busy produces only one transaction.
